// File: rtl/moore_seq_param.sv
// Parametrised one-hot Moore sequencer with programmable dwell and
// wrap / bounce / one-shot / hold stepping modes.
module moore_seq_param #(
  parameter int unsigned NUM_STATES = 4,
  parameter int unsigned DWELL_W    = 4,
  parameter int unsigned IDX_W      = $clog2(NUM_STATES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic                  load,
  input  logic [IDX_W-1:0]      load_idx,
  output logic [NUM_STATES-1:0] out,
  output logic [IDX_W-1:0]      idx,
  output logic                  wrap,
  output logic                  done
);

  typedef enum logic [1:0] {
    M_WRAP    = 2'd0,
    M_BOUNCE  = 2'd1,
    M_ONESHOT = 2'd2,
    M_HOLD    = 2'd3
  } mode_e;

  localparam logic [IDX_W-1:0]      LAST    = IDX_W'(NUM_STATES - 1);
  localparam logic [IDX_W-1:0]      FIRST   = '0;
  localparam logic [NUM_STATES-1:0] ONE_HOT = NUM_STATES'(1);

  // hd: bounce heading, 0 = up, 1 = down
  logic [DWELL_W-1:0]    cnt, cnt_n;
  logic [IDX_W-1:0]      idx_n, ld_idx_c, term_c;
  logic [NUM_STATES-1:0] out_n;
  logic                  hd, hd_n, wrap_n, done_n;
  mode_e                 mode_c;

  assign mode_c = mode_e'(mode);

  // Clamp only matters when the index field can encode unused states
  if (NUM_STATES < (1 << IDX_W)) begin : g_clamp
    assign ld_idx_c = (load_idx > LAST) ? LAST : load_idx;
  end else begin : g_noclamp
    assign ld_idx_c = load_idx;
  end

  assign term_c = dir ? FIRST : LAST;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      out  <= ONE_HOT;
      cnt  <= '0;
      hd   <= 1'b0;
      wrap <= 1'b0;
      done <= 1'b0;
    end else begin
      idx  <= idx_n;
      out  <= out_n;
      cnt  <= cnt_n;
      hd   <= hd_n;
      wrap <= wrap_n;
      done <= done_n;
    end
  end

  // Next-state: load beats enable; a frozen one-shot ignores enable
  always_comb begin
    idx_n  = idx;
    cnt_n  = cnt;
    hd_n   = hd;
    wrap_n = 1'b0;
    done_n = done;
    if (load) begin
      idx_n  = ld_idx_c;
      cnt_n  = '0;
      hd_n   = dir;
      done_n = 1'b0;
    end else if (en && !(mode_c == M_ONESHOT && done)) begin
      if (cnt < dwell) begin
        cnt_n = cnt + DWELL_W'(1);
      end else begin
        cnt_n = '0;
        case (mode_c)
          M_WRAP: begin
            if (!dir) begin
              idx_n  = (idx == LAST) ? FIRST : idx + IDX_W'(1);
              wrap_n = (idx == LAST);
            end else begin
              idx_n  = (idx == FIRST) ? LAST : idx - IDX_W'(1);
              wrap_n = (idx == FIRST);
            end
          end
          M_BOUNCE: begin
            if (!hd && idx == LAST) begin
              idx_n  = idx - IDX_W'(1);
              hd_n   = 1'b1;
              wrap_n = 1'b1;
            end else if (hd && idx == FIRST) begin
              idx_n  = idx + IDX_W'(1);
              hd_n   = 1'b0;
              wrap_n = 1'b1;
            end else begin
              idx_n = hd ? idx - IDX_W'(1) : idx + IDX_W'(1);
            end
          end
          M_ONESHOT: begin
            if (idx != term_c) idx_n = dir ? idx - IDX_W'(1) : idx + IDX_W'(1);
            if (idx_n == term_c) done_n = 1'b1;
          end
          default: ;
        endcase
      end
    end
    out_n = ONE_HOT << idx_n;
  end

endmodule

// File: tb/tb_moore_seq_param.sv
// Directed plus random checks of moore_seq_param against an integer reference model.
module tb_moore_seq_param;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst, en, dir, load;
  logic [1:0] mode, load_idx;
  logic [3:0] dwell;
  logic [N-1:0] out;
  logic [1:0] idx;
  logic       wrap, done;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_idx, m_cnt, m_up, m_done, m_wrap;

  always #5 clk = ~clk;

  moore_seq_param #(.NUM_STATES(N), .DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .dwell(dwell),
    .load(load), .load_idx(load_idx), .out(out), .idx(idx), .wrap(wrap), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge
  task automatic step(input logic r, input logic e, input logic d, input logic [1:0] m,
                      input logic [3:0] dw, input logic l, input logic [1:0] li);
    int nxt, term;
    logic [N-1:0] exp_out;
    @(negedge clk);
    rst = r; en = e; dir = d; mode = m; dwell = dw; load = l; load_idx = li;
    m_wrap = 0;
    if (r) begin
      m_idx = 0; m_cnt = 0; m_up = 1; m_done = 0;
    end else if (l) begin
      m_idx = (int'(li) > N - 1) ? N - 1 : int'(li);
      m_cnt = 0; m_done = 0; m_up = d ? 0 : 1;
    end else if (e && !(m == 2 && m_done == 1)) begin
      if (m_cnt < int'(dw)) m_cnt++;
      else begin
        m_cnt = 0;
        case (m)
          2'd0: begin
            nxt = m_idx + (d ? -1 : 1);
            if (nxt < 0 || nxt >= N) m_wrap = 1;
            m_idx = (nxt + N) % N;
          end
          2'd1: begin
            if ((m_up == 1 && m_idx == N - 1) || (m_up == 0 && m_idx == 0)) begin
              m_up = 1 - m_up;
              m_wrap = 1;
            end
            m_idx += (m_up == 1) ? 1 : -1;
          end
          2'd2: begin
            term = d ? 0 : N - 1;
            if (m_idx != term) m_idx += d ? -1 : 1;
            if (m_idx == term) m_done = 1;
          end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    exp_out = N'(1) << m_idx;
    check("out", 32'(out), 32'(exp_out));
    check("idx", 32'(idx), 32'(m_idx));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("done", 32'(done), 32'(m_done));
  endtask

  initial begin
    int bseq [7] = '{1, 2, 3, 2, 1, 0, 1};
    rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 2'd0; dwell = 4'd0; load = 1'b0; load_idx = 2'd0;
    m_idx = 0; m_cnt = 0; m_up = 1; m_done = 0; m_wrap = 0;

    // reset state
    step(1, 0, 0, 2'd0, 4'd0, 0, 2'd0);
    step(1, 1, 0, 2'd0, 4'd0, 0, 2'd0);
    check("reset_out", 32'(out), 32'h1);

    // WRAP up, dwell 0
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 2'd0, 4'd0, 0, 2'd0);
      if (i == 3) begin
        check("wrap_up_out", 32'(out), 32'h1);
        check("wrap_up_pulse", 32'(wrap), 32'h1);
      end
    end
    step(1, 1, 0, 2'd0, 4'd0, 0, 2'd0);
    check("mid_rst_out", 32'(out), 32'h1);

    // dwell 2 with enable gating
    step(0, 1, 0, 2'd0, 4'd2, 0, 2'd0);
    step(0, 0, 0, 2'd0, 4'd2, 0, 2'd0);
    step(0, 1, 0, 2'd0, 4'd2, 0, 2'd0);
    check("dwell_hold_idx", 32'(idx), 32'h0);
    step(0, 1, 0, 2'd0, 4'd2, 0, 2'd0);
    check("dwell_adv_idx", 32'(idx), 32'h1);
    step(0, 1, 0, 2'd0, 4'd2, 0, 2'd0);

    // BOUNCE from 0, dir toggling ignored
    step(1, 0, 0, 2'd0, 4'd0, 0, 2'd0);
    for (int i = 0; i < 7; i++) begin
      step(0, 1, i[0], 2'd1, 4'd0, 0, 2'd0);
      check("bounce_idx", 32'(idx), 32'(bseq[i]));
    end

    // ONESHOT down from a load of 2
    step(0, 1, 1, 2'd2, 4'd0, 1, 2'd2);
    check("os_load_idx", 32'(idx), 32'h2);
    step(0, 1, 1, 2'd2, 4'd0, 0, 2'd0);
    step(0, 1, 1, 2'd2, 4'd0, 0, 2'd0);
    check("os_done", 32'(done), 32'h1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 2'd2, 4'd0, 0, 2'd0);
    check("os_frozen_idx", 32'(idx), 32'h0);
    step(0, 1, 1, 2'd2, 4'd0, 1, 2'd3);
    check("os_reload_done", 32'(done), 32'h0);
    check("os_reload_idx", 32'(idx), 32'h3);

    // Load priority over enable mid-dwell, max index
    step(0, 1, 0, 2'd0, 4'd3, 0, 2'd0);
    step(0, 1, 0, 2'd0, 4'd3, 1, 2'd3);
    check("ld_prio_idx", 32'(idx), 32'h3);
    check("ld_prio_wrap", 32'(wrap), 32'h0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 2'd0, 4'd3, 0, 2'd0);
    check("ld_cnt_cleared", 32'(idx), 32'h0);

    // WRAP down from 0, then HOLD
    step(1, 0, 0, 2'd0, 4'd0, 0, 2'd0);
    step(0, 1, 1, 2'd0, 4'd0, 0, 2'd0);
    check("wrap_dn_idx", 32'(idx), 32'h3);
    check("wrap_dn_pulse", 32'(wrap), 32'h1);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 2'd3, 4'd0, 0, 2'd0);
    check("hold_out", 32'(out), 32'h8);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) != 0), 1'($urandom),
           2'($urandom), 4'($urandom_range(0, 3)), ($urandom_range(0, 99) < 5),
           2'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
